// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared Wishbone definitions for the RAM responder:
//   - bus widths (address, data, byte select)
//   - responder FSM state type
//   - wb_in_window(): address range check against a word window
// -----------------------------------------------------------------------------
package wb_pkg;

   localparam int unsigned WB_ADDR_W = 32;
   localparam int unsigned WB_DAT_W  = 32;
   localparam int unsigned WB_SEL_W  = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } wb_slv_state_t;

   // 1 when base <= addr < base + 4*depth. Done in 33 bits so a window ending
   // at the top of the address space cannot wrap.
   function automatic logic wb_in_window(input logic [WB_ADDR_W-1:0] addr,
                                         input logic [WB_ADDR_W-1:0] base,
                                         input int unsigned          depth);
      logic [WB_ADDR_W:0] a;
      logic [WB_ADDR_W:0] lo;
      logic [WB_ADDR_W:0] hi;
      a  = {1'b0, addr};
      lo = {1'b0, base};
      hi = lo + ({1'b0, depth} << 2);
      return (a >= lo) && (a < hi);
   endfunction

endpackage

// File: rtl/wb_byte_ram.sv
// -----------------------------------------------------------------------------
// wb_byte_ram
// Single-port synchronous RAM, 32-bit words with per-byte write enables.
// Read is synchronous and returns the word as it was before a same-edge write.
// Ports:
//   clk_i    clock
//   en_i     access enable (read issued when high)
//   we_i     byte write enables, bit n writes wdata_i[8n+7:8n]
//   addr_i   word index
//   wdata_i  write data
//   rdata_o  registered read data
// -----------------------------------------------------------------------------
module wb_byte_ram
   import wb_pkg::*;
#(
   parameter int unsigned Depth = 256,
   parameter int unsigned AddrW = 8
) (
   input  logic                clk_i,
   input  logic                en_i,
   input  logic [WB_SEL_W-1:0] we_i,
   input  logic [AddrW-1:0]    addr_i,
   input  logic [WB_DAT_W-1:0] wdata_i,
   output logic [WB_DAT_W-1:0] rdata_o
);

   logic [WB_DAT_W-1:0] mem_q [Depth];
   logic [WB_DAT_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         for (int n = 0; n < int'(WB_SEL_W); n++) begin
            if (we_i[n]) begin
               mem_q[addr_i][8*n +: 8] <= wdata_i[8*n +: 8];
            end
         end
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_ram_slave.sv
// -----------------------------------------------------------------------------
// wb_ram_slave
// Wishbone B4 classic responder in front of a byte-writable word RAM.
// Each qualified request (cyc & stb) gets exactly one registered ACK or ERR,
// WAIT_STATES + 1 cycles after the sampling edge. Read data accompanies ACK.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   wbs_cyc_i/stb_i   cycle valid / transfer strobe
//   wbs_we_i          1 = write
//   wbs_addr_i        byte address
//   wbs_dat_i         write data
//   wbs_sel_i         byte lane enables
//   wbs_dat_o         read data (zero outside a read ACK)
//   wbs_ack_o         normal termination
//   wbs_err_o         error termination
// -----------------------------------------------------------------------------
module wb_ram_slave
   import wb_pkg::*;
#(
   parameter logic [WB_ADDR_W-1:0] ADDR_BASE   = 32'h0000_1000,
   parameter int unsigned          DEPTH_WORDS = 256,
   parameter int unsigned          WAIT_STATES = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 wbs_cyc_i,
   input  logic                 wbs_stb_i,
   input  logic                 wbs_we_i,
   input  logic [WB_ADDR_W-1:0] wbs_addr_i,
   input  logic [WB_DAT_W-1:0]  wbs_dat_i,
   input  logic [WB_SEL_W-1:0]  wbs_sel_i,
   output logic [WB_DAT_W-1:0]  wbs_dat_o,
   output logic                 wbs_ack_o,
   output logic                 wbs_err_o
);

   localparam int unsigned AW       = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  WaitInit = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   wb_slv_state_t        state_q;
   logic [3:0]           cnt_q;
   logic                 req_we_q;
   logic                 req_err_q;
   logic [AW-1:0]        req_idx_q;
   logic [WB_DAT_W-1:0]  req_dat_q;
   logic [WB_SEL_W-1:0]  req_sel_q;
   logic                 ack_q;
   logic                 err_q;
   logic [WB_DAT_W-1:0]  dat_q;

   logic                 req_live;
   logic                 live_err;
   logic [AW-1:0]        live_idx;

   logic                 ram_en;
   logic [WB_SEL_W-1:0]  ram_we;
   logic [AW-1:0]        ram_idx;
   logic [WB_DAT_W-1:0]  ram_wdat;
   logic [WB_DAT_W-1:0]  ram_rdata;

   assign req_live = wbs_cyc_i & wbs_stb_i;
   assign live_err = !wb_in_window(wbs_addr_i, ADDR_BASE, DEPTH_WORDS) ||
                     (wbs_addr_i[1:0] != 2'b00) || (wbs_sel_i == '0);
   assign live_idx = AW'((wbs_addr_i - ADDR_BASE) >> 2);

   // RAM is accessed only on the edge that enters RESP. With no wait states
   // that edge is the sampling edge, so the live bus is used directly.
   always_comb begin
      ram_en   = 1'b0;
      ram_we   = '0;
      ram_idx  = req_idx_q;
      ram_wdat = req_dat_q;
      if (state_q == IDLE && req_live && WAIT_STATES == 0) begin
         ram_en   = !live_err;
         ram_we   = (wbs_we_i && !live_err) ? wbs_sel_i : '0;
         ram_idx  = live_idx;
         ram_wdat = wbs_dat_i;
      end else if (state_q == WAIT && cnt_q == 4'd0 && req_live) begin
         ram_en = !req_err_q;
         ram_we = (req_we_q && !req_err_q) ? req_sel_q : '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         req_we_q  <= 1'b0;
         req_err_q <= 1'b0;
         req_idx_q <= '0;
         req_dat_q <= '0;
         req_sel_q <= '0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         dat_q     <= '0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         dat_q <= '0;
         case (state_q)
            IDLE: begin
               if (req_live) begin
                  req_we_q  <= wbs_we_i;
                  req_err_q <= live_err;
                  req_idx_q <= live_idx;
                  req_dat_q <= wbs_dat_i;
                  req_sel_q <= wbs_sel_i;
                  if (WAIT_STATES == 0) begin
                     state_q <= RESP;
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= WaitInit;
                  end
               end
            end
            WAIT: begin
               if (!req_live) begin
                  // master withdrew: abandon without touching RAM or responding
                  state_q <= IDLE;
                  cnt_q   <= 4'd0;
               end else if (cnt_q == 4'd0) begin
                  state_q <= RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            RESP: begin
               state_q <= IDLE;
               if (req_err_q) begin
                  err_q <= 1'b1;
               end else begin
                  ack_q <= 1'b1;
                  if (!req_we_q) begin
                     dat_q <= ram_rdata;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   wb_byte_ram #(
      .Depth (DEPTH_WORDS),
      .AddrW (AW)
   ) u_ram (
      .clk_i   (clk_i),
      .en_i    (ram_en),
      .we_i    (ram_we),
      .addr_i  (ram_idx),
      .wdata_i (ram_wdat),
      .rdata_o (ram_rdata)
   );

   assign wbs_ack_o = ack_q;
   assign wbs_err_o = err_q;
   assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_wb_ram_slave.sv
module tb_wb_ram_slave;

   localparam logic [31:0] Base  = 32'h0000_1000;
   localparam int unsigned Depth = 256;
   localparam int unsigned Ws    = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc = 1'b0;
   logic        stb = 1'b0;
   logic        we  = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdat = '0;
   logic [3:0]  sel  = '0;
   logic [31:0] rdat;
   logic        ack;
   logic        err;

   wb_ram_slave #(
      .ADDR_BASE   (Base),
      .DEPTH_WORDS (Depth),
      .WAIT_STATES (Ws)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .wbs_cyc_i  (cyc),
      .wbs_stb_i  (stb),
      .wbs_we_i   (we),
      .wbs_addr_i (addr),
      .wbs_dat_i  (wdat),
      .wbs_sel_i  (sel),
      .wbs_dat_o  (rdat),
      .wbs_ack_o  (ack),
      .wbs_err_o  (err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;   // number of rising edges so far

   always @(posedge clk) cyc_n <= cyc_n + 1;

   typedef struct {
      int          due;
      logic        ack;
      logic        err;
      logic [31:0] dat;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mem_m [Depth];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   function automatic logic model_err(input logic [31:0] a, input logic [3:0] s);
      longint unsigned la;
      la = 64'(a);
      return (la < 64'(Base)) || (la >= 64'(Base) + 4 * 64'(Depth)) ||
             (a % 4 != 0) || (s == 4'b0000);
   endfunction

   // Every cycle: outputs must be idle unless a response is due in this cycle.
   always @(negedge clk) begin
      logic        ea;
      logic        ee;
      logic [31:0] ed;
      ea = 1'b0;
      ee = 1'b0;
      ed = '0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc_n) begin
         ea = exp_q[0].ack;
         ee = exp_q[0].err;
         ed = exp_q[0].dat;
         void'(exp_q.pop_front());
      end
      chk($sformatf("cmp_ack@%0d", cyc_n), 32'(ack), 32'(ea));
      chk($sformatf("cmp_err@%0d", cyc_n), 32'(err), 32'(ee));
      chk($sformatf("cmp_dat@%0d", cyc_n), rdat, ed);
   end

   // Called at a negedge; returns at the negedge of the response cycle with
   // the request still driven (caller decides whether to drop it).
   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic o_ack, output logic o_err,
                       output logic [31:0] o_dat);
      exp_t e;
      int   idx;
      cyc  = 1'b1;
      stb  = 1'b1;
      we   = w;
      addr = a;
      wdat = d;
      sel  = s;
      e.due = cyc_n + 2 + int'(Ws);
      e.err = model_err(a, s);
      e.ack = !e.err;
      e.dat = '0;
      if (!e.err) begin
         idx = int'((a - Base) / 4);
         if (w) begin
            for (int n = 0; n < 4; n++)
               if (s[n]) mem_m[idx][8*n +: 8] = d[8*n +: 8];
         end else begin
            e.dat = mem_m[idx];
         end
      end
      exp_q.push_back(e);
      while (cyc_n != e.due) @(negedge clk);
      o_ack = ack;
      o_err = err;
      o_dat = rdat;
   endtask

   task automatic idle();
      cyc = 1'b0;
      stb = 1'b0;
      @(negedge clk);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic        ra;
      logic        re;
      logic [31:0] rd;
      xfer(1'b1, a, d, s, ra, re, rd);
      idle();
   endtask

   task automatic rd_lit(input string name, input logic [31:0] a, input logic [31:0] expv);
      logic        ra;
      logic        re;
      logic [31:0] rd;
      xfer(1'b0, a, 32'h0, 4'hF, ra, re, rd);
      chk({name, "_ack"}, 32'(ra), 32'd1);
      chk({name, "_dat"}, rd, expv);
      idle();
   endtask

   task automatic err_lit(input string name, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
      logic        ra;
      logic        re;
      logic [31:0] rd;
      xfer(w, a, d, s, ra, re, rd);
      chk({name, "_err"}, 32'(re), 32'd1);
      chk({name, "_ack"}, 32'(ra), 32'd0);
      chk({name, "_dat"}, rd, 32'h0);
      idle();
   endtask

   initial begin
      logic        ra;
      logic        re;
      logic [31:0] rd;
      int          t_prev;

      #1;
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_dat", rdat, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Known contents for words read later.
      wr(32'h0000_1008, 32'hA5A5_0008, 4'hF);
      wr(32'h0000_100C, 32'h0C0C_0C0C, 4'hF);
      wr(32'h0000_13FC, 32'h1357_9BDF, 4'hF);
      wr(32'h0000_1000, 32'h0102_0304, 4'hF);
      rd_lit("first_word", 32'h0000_1000, 32'h0102_0304);

      // 1: full write, ACK exactly WAIT_STATES+1 cycles after sampling edge.
      t_prev = cyc_n;
      xfer(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, ra, re, rd);
      chk("t1_latency", 32'(cyc_n - t_prev), 32'd4);
      chk("t1_ack", 32'(ra), 32'd1);
      chk("t1_err", 32'(re), 32'd0);
      chk("t1_wdat", rd, 32'h0);
      idle();
      rd_lit("t1_rd", 32'h0000_1004, 32'hDEAD_BEEF);

      // 2: single byte lane write.
      wr(32'h0000_1004, 32'h0000_5500, 4'b0010);
      rd_lit("t2_rd", 32'h0000_1004, 32'hDEAD_55EF);

      // 3: window boundaries.
      err_lit("t3_past", 1'b1, 32'h0000_1400, 32'hFFFF_FFFF, 4'hF);
      err_lit("t3_below", 1'b1, 32'h0000_0FFC, 32'hFFFF_FFFF, 4'hF);
      rd_lit("t3_last", 32'h0000_13FC, 32'h1357_9BDF);

      // 4: misaligned read, empty select write.
      err_lit("t4_misal", 1'b0, 32'h0000_1006, 32'h0, 4'hF);
      err_lit("t4_sel0", 1'b1, 32'h0000_1004, 32'hFFFF_FFFF, 4'h0);
      rd_lit("t4_rd", 32'h0000_1004, 32'hDEAD_55EF);

      // 5: abort during WAIT (no expectation queued: no response allowed).
      cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h0000_1008;
      wdat = 32'h1234_5678; sel = 4'hF;
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0;
      repeat (5) @(negedge clk);
      rd_lit("t5_rd", 32'h0000_1008, 32'hA5A5_0008);

      // 6a: asynchronous reset mid-WAIT of a write.
      cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h0000_100C;
      wdat = 32'hFFFF_FFFF; sel = 4'hF;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("t6_state", 32'(dut.state_q), 32'(wb_pkg::IDLE));
      chk("t6_ack", 32'(ack), 32'd0);
      chk("t6_err", 32'(err), 32'd0);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rd_lit("t6_rd", 32'h0000_100C, 32'h0C0C_0C0C);

      // 6b: reset asserted inside an ACK cycle clears outputs without a clock edge.
      xfer(1'b0, 32'h0000_1004, 32'h0, 4'hF, ra, re, rd);
      chk("t6b_pre_dat", rd, 32'hDEAD_55EF);
      #2 rst = 1'b1;
      #1;
      chk("t6b_ack", 32'(ack), 32'd0);
      chk("t6b_dat", rdat, 32'h0);
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // 6c: back-to-back reads, one transfer every 2+WAIT_STATES cycles.
      t_prev = cyc_n;
      xfer(1'b0, 32'h0000_1004, 32'h0, 4'hF, ra, re, rd);
      chk("b2b0_dat", rd, 32'hDEAD_55EF);
      t_prev = cyc_n;
      xfer(1'b0, 32'h0000_1008, 32'h0, 4'hF, ra, re, rd);
      chk("b2b1_gap", 32'(cyc_n - t_prev), 32'd4);
      chk("b2b1_dat", rd, 32'hA5A5_0008);
      t_prev = cyc_n;
      xfer(1'b0, 32'h0000_100C, 32'h0, 4'hF, ra, re, rd);
      chk("b2b2_gap", 32'(cyc_n - t_prev), 32'd4);
      chk("b2b2_dat", rd, 32'h0C0C_0C0C);
      xfer(1'b1, 32'h0000_13FC, 32'hCAFE_F00D, 4'b1001, ra, re, rd);
      xfer(1'b0, 32'h0000_13FC, 32'h0, 4'hF, ra, re, rd);
      chk("b2b_wr_rd", rd, 32'hCA57_9B0D);
      idle();
      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
